// File: rtl/types_pkg.sv
// Shared fetch types: queue entry (pc, instr), FSM encoding, reset PC default, saturating add.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package types_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } fetch_state_e;

  // Clamps at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH-entry circular buffer of fetch_entry_t with push/pop/clear and occupancy.
// Latency: pushed entry visible at head the cycle after the push; no write-through bypass.
// Backpressure: pop ignored when empty; caller guarantees no push when full; clear wins over both.
module fetch_fifo
  import types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_dat_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic                     vld_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_eff;

  assign pop_eff = pop_i && (count_q != '0);

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_eff);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (!reset && !clear_i && push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign vld_o   = (count_q != '0);
  assign head_o  = vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC/epoch/inflight tracking and RUN/FULL FSM feeding fetch_fifo; FETCH_STATS_EN adds counters.
// Latency: request N -> enqueue end of N+1 -> fetch_valid_out N+2; redirect N -> request N+1 -> valid N+3.
// Backpressure: requests stop once queue plus inflight reach DEPTH; decode_ready_in low holds the head.
module fetch_unit
  import types_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     fetch_valid_out,
  output logic [31:0]              fetch_pc_out,
  output logic [31:0]              fetch_instr_out,
  input  logic                     decode_ready_in,
  output logic [$clog2(DEPTH):0]   fetch_count_out
`ifdef FETCH_STATS_EN
  ,output logic [31:0]             stat_fetched
  ,output logic [31:0]             stat_dropped
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          epoch_q, epoch_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          req_epoch_q, req_epoch_d;

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  fetch_entry_t  head;
  fetch_entry_t  push_dat;

  // A response is kept only if its request epoch is current and no redirect flushes this cycle.
  assign push     = inflight_q && (req_epoch_q == epoch_q) && !redirect_valid;
  assign pop      = fetch_valid_out && decode_ready_in;
  assign push_dat = '{pc: req_pc_q, instr: imem_rdata};
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);

  // Next-state: redirect dominates; otherwise issue while RUN and track FULL from next occupancy.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    inflight_d  = 1'b0;
    req_pc_d    = req_pc_q;
    req_epoch_d = req_epoch_q;
    issue       = 1'b0;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      epoch_d = ~epoch_q;
      state_d = ST_RUN;
    end else begin
      issue = !reset && (state_q == ST_RUN);
      if (issue) begin
        pc_d        = pc_q + 32'd4;
        inflight_d  = 1'b1;
        req_pc_d    = pc_q;
        req_epoch_d = epoch_q;
      end
      state_d = ((count_nxt + CW'(inflight_d)) == CW'(DEPTH)) ? ST_FULL : ST_RUN;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      epoch_q     <= 1'b0;
      inflight_q  <= 1'b0;
      req_pc_q    <= '0;
      req_epoch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      inflight_q  <= inflight_d;
      req_pc_q    <= req_pc_d;
      req_epoch_q <= req_epoch_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (redirect_valid),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .vld_o      (fetch_valid_out),
    .count_o    (fifo_count)
  );

  assign imem_req_valid  = issue;
  assign imem_addr       = pc_q;
  assign fetch_pc_out    = head.pc;
  assign fetch_instr_out = head.instr;
  assign fetch_count_out = fifo_count;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_dropped_q;
  logic [31:0] drop_amt;

  // Dropped words: a discarded response plus entries flushed by redirect (a same-cycle dequeue counts as consumed).
  always_comb begin
    drop_amt = {31'd0, inflight_q && !push};
    if (redirect_valid) drop_amt = drop_amt + 32'(fifo_count) - 32'(pop);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_fetched_q <= sat_add32(stat_fetched_q, {31'd0, push});
      stat_dropped_q <= sat_add32(stat_dropped_q, drop_amt);
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (DEPTH=4, RESET_PC=0); imem returns addr>>2.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: decode_ready_in driven directly by the step sequence.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        fetch_valid_out;
  logic [31:0] fetch_pc_out;
  logic [31:0] fetch_instr_out;
  logic        decode_ready_in;
  logic [2:0]  fetch_count_out;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .fetch_valid_out (fetch_valid_out),
    .fetch_pc_out    (fetch_pc_out),
    .fetch_instr_out (fetch_instr_out),
    .decode_ready_in (decode_ready_in),
    .fetch_count_out (fetch_count_out)
`ifdef FETCH_STATS_EN
    ,.stat_fetched   (stat_fetched)
    ,.stat_dropped   (stat_dropped)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: latch the request seen before the edge, answer it right after.
  task automatic tick();
    logic        pv;
    logic [31:0] pa;
    #1;
    pv = imem_req_valid;
    pa = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = pv ? (pa >> 2) : 32'hDEAD_BEEF;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, fetch_valid_out}, 32'd0);
    chk({tag, "_count"}, {29'd0, fetch_count_out}, 32'd0);
    chk({tag, "_pc"},    fetch_pc_out, 32'd0);
    chk({tag, "_instr"}, fetch_instr_out, 32'd0);
    chk({tag, "_req"},   {31'd0, imem_req_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    decode_ready_in = 1'b1; imem_rdata = '0;
    tick(); tick();
    chk_reset_state("por");

    // Streaming with decode always ready.
    reset = 1'b0; #1;
    chk("s_c0_req", {31'd0, imem_req_valid}, 32'd1);
    chk("s_c0_addr", imem_addr, 32'h0);
    tick();
    chk("s_c1_addr", imem_addr, 32'h4);
    chk("s_c1_valid", {31'd0, fetch_valid_out}, 32'd0);
    tick();
    chk("s_c2_valid", {31'd0, fetch_valid_out}, 32'd1);
    chk("s_c2_pc", fetch_pc_out, 32'h0);
    chk("s_c2_addr", imem_addr, 32'h8);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s_valid", {31'd0, fetch_valid_out}, 32'd1);
      chk("s_pc", fetch_pc_out, 32'(4 * k));
      chk("s_instr", fetch_instr_out, 32'(k));
      chk("s_count", {29'd0, fetch_count_out}, 32'd1);
    end

    // Decode stalled from reset: fill to FULL, then release.
    reset = 1'b1; decode_ready_in = 1'b0;
    tick();
    chk_reset_state("rst2");
    reset = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      chk("f_req", {31'd0, imem_req_valid}, 32'd1);
      chk("f_addr", imem_addr, 32'(4 * k));
      tick();
    end
    chk("f_c4_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("f_c5_req", {31'd0, imem_req_valid}, 32'd0);
    chk("f_c5_count", {29'd0, fetch_count_out}, 32'd4);
    chk("f_c5_pc", fetch_pc_out, 32'h0);
    tick();
    chk("f_hold_pc", fetch_pc_out, 32'h0);
    chk("f_hold_instr", fetch_instr_out, 32'h0);
    chk("f_hold_count", {29'd0, fetch_count_out}, 32'd4);
    decode_ready_in = 1'b1; #1;
    chk("f_full_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("f_resume_req", {31'd0, imem_req_valid}, 32'd1);
    chk("f_resume_addr", imem_addr, 32'h10);
    chk("f_resume_pc", fetch_pc_out, 32'h4);
    chk("f_resume_count", {29'd0, fetch_count_out}, 32'd3);
    decode_ready_in = 1'b0;
    tick(); tick();
    chk("f_refull_count", {29'd0, fetch_count_out}, 32'd4);

    // Reset with a full queue.
    reset = 1'b1;
    tick();
    chk_reset_state("rst3");
    reset = 1'b0; #1;
    chk("r_refetch_req", {31'd0, imem_req_valid}, 32'd1);
    chk("r_refetch_addr", imem_addr, 32'h0);

    // Redirect with 3 queued and one inflight.
    tick(); tick(); tick(); tick();
    chk("d_pre_count", {29'd0, fetch_count_out}, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("d_n_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0; decode_ready_in = 1'b1; #1;
    chk("d_n1_count", {29'd0, fetch_count_out}, 32'd0);
    chk("d_n1_valid", {31'd0, fetch_valid_out}, 32'd0);
    chk("d_n1_req", {31'd0, imem_req_valid}, 32'd1);
    chk("d_n1_addr", imem_addr, 32'h100);
    tick();
    chk("d_n2_valid", {31'd0, fetch_valid_out}, 32'd0);
    chk("d_n2_count", {29'd0, fetch_count_out}, 32'd0);
    chk("d_n2_addr", imem_addr, 32'h104);
    tick();
    chk("d_n3_valid", {31'd0, fetch_valid_out}, 32'd1);
    chk("d_n3_pc", fetch_pc_out, 32'h100);
    chk("d_n3_instr", fetch_instr_out, 32'h40);

    // Back-to-back redirects 0x200 then 0x300.
    reset = 1'b1; decode_ready_in = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("b_c3_count", {29'd0, fetch_count_out}, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0; decode_ready_in = 1'b1; #1;
    chk("b_c5_addr", imem_addr, 32'h300);
    chk("b_c5_valid", {31'd0, fetch_valid_out}, 32'd0);
    tick();
    chk("b_c6_valid", {31'd0, fetch_valid_out}, 32'd0);
    tick();
    chk("b_c7_valid", {31'd0, fetch_valid_out}, 32'd1);
    chk("b_c7_pc", fetch_pc_out, 32'h300);
    chk("b_c7_instr", fetch_instr_out, 32'hC0);
`ifdef FETCH_STATS_EN
    chk("b_stat_fetched", stat_fetched, 32'd3);
    chk("b_stat_dropped", stat_dropped, 32'd3);
`endif
    tick();
    chk("b_c8_pc", fetch_pc_out, 32'h304);

    // Redirect to the top word: PC wraps to zero.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; #1;
    chk("w_n1_req", {31'd0, imem_req_valid}, 32'd1);
    chk("w_n1_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("w_n2_addr", imem_addr, 32'h0);
    tick();
    chk("w_n3_pc", fetch_pc_out, 32'hFFFF_FFFC);
    chk("w_n3_instr", fetch_instr_out, 32'h3FFF_FFFF);
    tick();
    chk("w_n4_pc", fetch_pc_out, 32'h0);
    chk("w_n4_instr", fetch_instr_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, fetch-queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  taken jalr/bne or mispredict recovery; flush and refetch.
REQ-006 redirect_pc  input  32  new fetch address, qualified by redirect_valid.
REQ-007 imem_req_valid  output  1  instruction-memory read request this cycle.
REQ-008 imem_addr  output  32  read address, word aligned.
REQ-009 imem_rdata  input  32  instruction word, valid exactly one cycle after the accepted request.
REQ-010 fetch_valid_out  output  1  queue head valid toward frontend decode.
REQ-011 fetch_pc_out  output  32  PC of queue head.
REQ-012 fetch_instr_out  output  32  instruction word of queue head.
REQ-013 decode_ready_in  input  1  frontend accepts head; transfer when valid and ready both high.
REQ-014 fetch_count_out  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 The fetch PC SHALL issue a request when count + inflight < DEPTH and redirect_valid is low; after each issued request the PC increments by 4 (32-bit, wraps at 2^32).
REQ-016 inflight SHALL be 1 in the cycle after an issued request, else 0; the response SHALL be written to the queue tail at the end of that cycle, tagged with the request PC.
REQ-017 The dequeue SHALL occur on fetch_valid_out && decode_ready_in; head pointer advances, wraps modulo DEPTH.
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged; this is legal at full and at empty+1.
REQ-019 Latency: request at cycle N -> data enqueued at end of N+1 -> fetch_valid_out high in N+2; no bypass.
REQ-020 redirect_valid SHALL take priority over request, enqueue, and dequeue: queue cleared (count 0), PC <= redirect_pc, no request that cycle, outstanding response discarded.
REQ-021 Stale responses SHALL be discarded via a 1-bit epoch toggled on redirect and carried with each request.
REQ-022 After a redirect in cycle N: request for redirect_pc in N+1, fetch_valid_out in N+3.
REQ-023 The output head SHALL hold stable while fetch_valid_out is high and decode_ready_in is low.
REQ-024 A two-state FSM SHALL be used: RUN (requests allowed) and FULL (count + inflight == DEPTH); FULL -> RUN on dequeue; any state -> RUN on redirect.
REQ-025 Redirect in the same cycle as a dequeue SHALL NOT present the dequeued instruction again; it is considered consumed.

Reset
REQ-026 On reset: PC = RESET_PC, queue empty, inflight 0, epoch 0, FSM RUN, imem_req_valid 0, fetch_valid_out 0, fetch_pc_out 0, fetch_instr_out 0, fetch_count_out 0.
REQ-027 The first request SHALL issue in the first cycle after reset deasserts; a response arriving in a reset cycle SHALL be dropped.

Configuration
REQ-028 Macro FETCH_STATS_EN compiled in SHALL add 32-bit saturating output counters stat_fetched (enqueued words) and stat_dropped (discarded responses plus flushed entries), both cleared on reset.
REQ-029 Without FETCH_STATS_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-030 The fetch_entry struct (pc, instr) and the RESET_PC default SHALL live in types_pkg.
REQ-031 The queue SHALL be one sub-module, fetch_fifo (DEPTH entries, push/pop/clear, count); fetch_unit holds PC, epoch, inflight, and FSM.

Verification
REQ-032 Reset, decode_ready_in=1, imem returns addr>>2: requests 0,4,8,...; fetch_valid_out first at cycle 2 with pc 0; one instruction per cycle thereafter.
REQ-033 decode_ready_in=0 from reset: exactly 4 requests (0..12), FULL state, imem_req_valid stays 0; raising ready resumes with request 16 the next cycle.
REQ-034 Redirect to 32'h100 while queue holds 3 entries and a request is inflight: count 0 next cycle, stale word not enqueued, request 0x100 in N+1, valid with pc 0x100 in N+3.
REQ-035 Back-to-back redirects (0x200 then 0x300): only 0x300 instructions reach decode; FETCH_STATS_EN stat_dropped counts every discarded word.
REQ-036 Redirect_pc 32'hFFFFFFFC: next fetch PCs 0xFFFFFFFC, then 0x00000000.
REQ-037 Reset asserted mid-stream with full queue: all outputs return to reset values next cycle, refetch starts at RESET_PC.
